// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage: sign/zero-extends raw immediates by opcode,
// pre-shifts BZ/J offsets, and optionally merges a one-level prefix (IMM_PREFIX_EN).
module imm_ext_stage #(
  parameter int               IMM_W     = 14,
  parameter int               DATA_W    = 32,
  parameter int               OPC_W     = 6,
  parameter int               TAG_W     = 32,
  parameter int               OFF_SHIFT = 0,
  parameter logic [OPC_W-1:0] PFX_OPC   = OPC_W'(6'b001111)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [DATA_W-1:0] out_imm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_prefixed
);

  localparam logic [OPC_W-1:0] OPC_ORI = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OPC_BZ  = OPC_W'(6'b001010);
  localparam logic [OPC_W-1:0] OPC_J   = OPC_W'(6'b001110);

  logic                 accept;
  logic                 is_pfx;
  logic                 load_en;
  logic                 use_pfx;
  logic [IMM_W-1:0]     pfx_bits;
  logic [2*IMM_W-1:0]   long_imm;
  logic [DATA_W-1:0]    ext_val;
  logic [DATA_W-1:0]    final_val;

  assign in_ready = rst_n && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_pfx   = (in_opcode == PFX_OPC);

`ifdef IMM_PREFIX_EN
  typedef enum logic {IDLE, HELD} pfx_state_t;
  pfx_state_t       state_reg, state_next;
  logic [IMM_W-1:0] pfx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pfx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept && is_pfx)
        pfx_reg <= in_imm;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush)
      state_next = IDLE;
    else if (accept)
      state_next = is_pfx ? HELD : IDLE;
  end

  // A prefix instruction is absorbed into pfx_reg and never reaches the output.
  assign load_en  = accept && !is_pfx;
  assign use_pfx  = (state_reg == HELD);
  assign pfx_bits = pfx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_prefixed <= 1'b0;
    else if (!flush && load_en)
      out_prefixed <= use_pfx;
  end
`else
  assign load_en      = accept;
  assign use_pfx      = 1'b0;
  assign pfx_bits     = '0;
  assign out_prefixed = 1'b0;
`endif

  assign long_imm = {pfx_bits, in_imm};

  // Sign bit sits at IMM_W-1 for a plain immediate and at 2*IMM_W-1 when prefixed.
  always_comb begin
    ext_val = '0;
    if (use_pfx) begin
      if (in_opcode == OPC_ORI)
        ext_val = DATA_W'(long_imm);
      else
        ext_val = DATA_W'($signed(long_imm));
    end else begin
      if (in_opcode == OPC_ORI)
        ext_val = DATA_W'(in_imm);
      else
        ext_val = DATA_W'($signed(in_imm));
    end
    final_val = ext_val;
    if (in_opcode == OPC_BZ || in_opcode == OPC_J)
      final_val = ext_val << OFF_SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_imm    <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_en) begin
      out_valid  <= 1'b1;
      out_opcode <= in_opcode;
      out_imm    <= final_val;
      out_tag    <= in_tag;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // is_pfx only matters for the prefix build; keep it referenced otherwise.
  logic unused_ok;
  assign unused_ok = is_pfx;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed self-checking bench for imm_ext_stage (OFF_SHIFT=2); prefix checks
// follow IMM_PREFIX_EN.
module tb_imm_ext_stage;

  localparam logic [5:0] OPC_ADDI = 6'b000001;
  localparam logic [5:0] OPC_ORI  = 6'b000100;
  localparam logic [5:0] OPC_BZ   = 6'b001010;
  localparam logic [5:0] OPC_J    = 6'b001110;
  localparam logic [5:0] OPC_PFX  = 6'b001111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [13:0] in_imm;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [31:0] out_imm;
  logic [31:0] out_tag;
  logic        out_prefixed;

  int n_cmp  = 0;
  int n_fail = 0;

  imm_ext_stage #(
    .IMM_W(14), .DATA_W(32), .OPC_W(6), .TAG_W(32), .OFF_SHIFT(2), .PFX_OPC(6'b001111)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_imm(out_imm), .out_tag(out_tag),
    .out_prefixed(out_prefixed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    $display("check %-18s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic drive(input logic [5:0] opc, input logic [13:0] imm, input logic [31:0] tg);
    in_valid  = 1'b1;
    in_opcode = opc;
    in_imm    = imm;
    in_tag    = tg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_imm = '0; in_tag = '0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    rst_n = 1'b1;
    drive(OPC_ADDI, 14'h0005, 32'h100);
    tick();
    chk("addi5_valid", 32'(out_valid), 32'd1);
    chk("addi5_imm", out_imm, 32'h5);

    // asynchronous reset mid-stream with in_valid still high
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_imm", out_imm, 32'd0);
    chk("async_out_tag", out_tag, 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(OPC_ORI, 14'h3FFF, 32'h104);
    #1;
    chk("post_rst_pre_valid", 32'(out_valid), 32'd0);
    tick();
    chk("ori_valid", 32'(out_valid), 32'd1);
    chk("ori_imm", out_imm, 32'h00003FFF);
    chk("ori_opcode", 32'(out_opcode), 32'(OPC_ORI));

    // back-to-back issue
    drive(OPC_ADDI, 14'h2000, 32'h108);
    tick();
    chk("addi_neg_imm", out_imm, 32'hFFFFE000);
    chk("addi_neg_tag", out_tag, 32'h108);
    drive(OPC_BZ, 14'h3F00, 32'h10C);
    tick();
    chk("bz_imm", out_imm, 32'hFFFFFC00);
    chk("bz_valid", 32'(out_valid), 32'd1);
    drive(OPC_J, 14'h0100, 32'h110);
    tick();
    chk("j_imm", out_imm, 32'h00000400);
    chk("j_opcode", 32'(out_opcode), 32'(OPC_J));
    in_valid = 1'b0;
    tick();
    chk("retire_valid", 32'(out_valid), 32'd0);
    chk("retire_imm_held", out_imm, 32'h00000400);

    // stall with a pending result
    out_ready = 1'b0;
    drive(OPC_ADDI, 14'h0007, 32'h77);
    tick();
    chk("stall_load_imm", out_imm, 32'h7);
    drive(OPC_ORI, 14'h0010, 32'h88);
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_imm", out_imm, 32'h7);
      chk("stall_tag", out_tag, 32'h77);
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("swap_valid", 32'(out_valid), 32'd1);
    chk("swap_imm", out_imm, 32'h10);
    chk("swap_tag", out_tag, 32'h88);

    // flush during stall
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    chk("pre_flush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    out_ready = 1'b1;

`ifdef IMM_PREFIX_EN
    drive(OPC_PFX, 14'h0001, 32'h200);
    tick();
    chk("pfx1_no_output", 32'(out_valid), 32'd0);
    drive(OPC_ADDI, 14'h0000, 32'h204);
    tick();
    chk("pfx1_valid", 32'(out_valid), 32'd1);
    chk("pfx1_imm", out_imm, 32'h00004000);
    chk("pfx1_prefixed", 32'(out_prefixed), 32'd1);
    chk("pfx1_tag", out_tag, 32'h204);

    drive(OPC_PFX, 14'h2000, 32'h208);
    tick();
    chk("pfx2_no_output", 32'(out_valid), 32'd0);
    drive(OPC_ORI, 14'h0005, 32'h20C);
    tick();
    chk("pfx2_ori_imm", out_imm, 32'h08000005);

    drive(OPC_PFX, 14'h2000, 32'h210);
    tick();
    drive(OPC_ADDI, 14'h0005, 32'h214);
    tick();
    chk("pfx3_addi_imm", out_imm, 32'hF8000005);
    chk("pfx3_prefixed", 32'(out_prefixed), 32'd1);

    // prefix survives an idle cycle
    drive(OPC_PFX, 14'h0001, 32'h218);
    tick();
    in_valid = 1'b0;
    tick();
    drive(OPC_ADDI, 14'h0000, 32'h21C);
    tick();
    chk("pfx_idle_imm", out_imm, 32'h00004000);

    // flush discards a held prefix
    drive(OPC_PFX, 14'h0001, 32'h220);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
`else
    drive(OPC_PFX, 14'h0001, 32'h200);
    tick();
    chk("pfxop_valid", 32'(out_valid), 32'd1);
    chk("pfxop_imm", out_imm, 32'h1);
    chk("pfxop_prefixed", 32'(out_prefixed), 32'd0);
    drive(OPC_PFX, 14'h2000, 32'h204);
    tick();
    chk("pfxop_sext_imm", out_imm, 32'hFFFFE000);
`endif
    drive(OPC_ADDI, 14'h0005, 32'h224);
    tick();
    chk("post_flush_imm", out_imm, 32'h00000005);
    chk("post_flush_pfx", 32'(out_prefixed), 32'd0);
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
